// File: rtl/flag_branch_ctrl.sv
// flag_branch_ctrl: architectural N/V/Z flag register, branch resolver,
// program counter sequencer and saturating taken-branch counter for the
// single-cycle core. Two-state FSM (RUN / HALTED); HALTED is sticky until rst.
module flag_branch_ctrl #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  FLAG_alu,
  input  logic        flag_we,
  output logic [2:0]  FLAG_q,
  input  logic        pc_en,
  input  logic        is_B,
  input  logic        is_BR,
  input  logic [2:0]  cond,
  input  logic [8:0]  imm9,
  input  logic [15:0] reg_target,
  input  logic        halt,
  output logic [15:0] PC,
  output logic [15:0] PC_plus2,
  output logic        taken,
  output logic        halted,
  output logic [15:0] br_count
);

  typedef enum logic {S_RUN, S_HALTED} state_t;

  state_t      state_q, state_d;
  logic [15:0] pc_q, pc_d;
  logic [2:0]  flags_q, flags_d;
  logic [15:0] cnt_q, cnt_d;

  logic               cond_true;
  logic               active;
  logic signed [15:0] br_off;
  logic [15:0]        br_target;

  // Condition codes are judged against the registered flags only, so a flag
  // write and a branch in the same cycle see the old flags.
  function automatic logic eval_cond(input logic [2:0] c, input logic [2:0] f);
    logic n, v, z;
    n = f[0];
    v = f[1];
    z = f[2];
    case (c)
      3'b000:  eval_cond = ~z;
      3'b001:  eval_cond = z;
      3'b010:  eval_cond = ~z & ~n;
      3'b011:  eval_cond = n;
      3'b100:  eval_cond = z | ~n;
      3'b101:  eval_cond = n | z;
      3'b110:  eval_cond = v;
      default: eval_cond = 1'b1;
    endcase
  endfunction

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  function automatic logic [15:0] sat_inc(input logic [15:0] x);
    sat_inc = (x == 16'hFFFF) ? x : x + 16'd1;
  endfunction

  // Branch resolution, next-PC selection and next-state logic.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    flags_d   = flags_q;
    cnt_d     = cnt_q;
    PC_plus2  = pc_q + 16'd2;
    br_off    = {{6{imm9[8]}}, imm9, 1'b0};
    br_target = PC_plus2 + br_off;
    cond_true = eval_cond(cond, flags_q);
    // halt dominates: the HLT cycle makes no flag write, branch or count.
    active    = pc_en & ~halt & (state_q == S_RUN);
    taken     = (is_B | is_BR) & cond_true & active;

    if (state_q == S_RUN && pc_en) begin
      if (halt) begin
        state_d = S_HALTED;
      end else begin
        if (flag_we) flags_d = FLAG_alu;
        if (taken) begin
          // is_BR wins over is_B on an illegal double decode.
          pc_d  = is_BR ? reg_target : br_target;
          cnt_d = sat_inc(cnt_q);
        end else begin
          pc_d = PC_plus2;
        end
      end
    end
  end

  // State registers; rst restores every register and returns to RUN.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_RUN;
      pc_q    <= RESET_PC;
      flags_q <= 3'b000;
      cnt_q   <= 16'h0000;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      flags_q <= flags_d;
      cnt_q   <= cnt_d;
    end
  end

  assign PC       = pc_q;
  assign FLAG_q   = flags_q;
  assign halted   = (state_q == S_HALTED);
  assign br_count = cnt_q;

endmodule

// File: doc/flag_branch_ctrl.md
# flag_branch_ctrl

Architectural flag register, branch resolver and program counter for the single-cycle core. It latches the N/V/Z flags produced by the ALU and feeds them back to the ALU's flag input. It evaluates branch conditions against the latched flags, sequences the PC (sequential, PC-relative, register-indirect, halt), and counts taken branches.

## Interface

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.

Ports:
- clk, input, 1, core clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- FLAG_alu, input, 3, flags from the ALU, already merged with FLAG_q: [0]=N, [1]=V, [2]=Z.
- flag_we, input, 1, commit FLAG_alu into the flag register this cycle.
- FLAG_q, output, 3, registered flags; same bit order; drives the ALU FLAG_in.
- pc_en, input, 1, when 0 the cycle is a stall and all state holds.
- is_B, input, 1, PC-relative conditional branch.
- is_BR, input, 1, register-indirect conditional branch.
- cond, input, 3, condition code of the branch.
- imm9, input, 9, signed word offset for is_B.
- reg_target, input, 16, target address for is_BR.
- halt, input, 1, HLT instruction decoded.
- PC, output, 16, current instruction address (registered).
- PC_plus2, output, 16, PC+2 (combinational), used by PCS writeback.
- taken, output, 1, the branch in this cycle is taken (combinational).
- halted, output, 1, the core is in the HALTED state (registered).
- br_count, output, 16, saturating count of committed taken branches.

## Operation

- Reset values: PC=RESET_PC, FLAG_q=3'b000, halted=0, br_count=0.
- State machine: RUN and HALTED.
  - In RUN with pc_en=1 and halt=1: the state moves to HALTED and PC holds its value.
  - HALTED is left only by rst.
- Condition evaluation uses FLAG_q, the registered value, never FLAG_alu:
  - 000 NE: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 and N=0.
  - 011 LT: N=1.
  - 100 GTE: Z=1 or N=0.
  - 101 LTE: N=1 or Z=1.
  - 110 OV: V=1.
  - 111: always taken.
- taken = (is_B | is_BR) & cond_true & ~halt & ~halted & pc_en.
- Next PC, in priority order:
  - rst → RESET_PC.
  - halted, halt, or pc_en=0 → hold.
  - taken & is_BR → reg_target, used as given with no alignment change.
  - taken & is_B → PC_plus2 + (sign_extend(imm9) << 1), computed modulo 2^16 (wraps silently).
  - otherwise → PC_plus2, which also wraps from 16'hFFFE to 16'h0000.
- is_B and is_BR both asserted is illegal decode. is_BR has priority.
- Flag register: FLAG_q <= FLAG_alu when flag_we & pc_en & ~halt & ~halted; otherwise it holds.
- halt dominates: in the halt cycle there is no flag write, no branch, and no count.
- br_count increments on every cycle where taken=1. It saturates at 16'hFFFF and never wraps.

## Timing

- PC, FLAG_q, halted and br_count are registered, with 1-cycle update latency.
- taken and PC_plus2 are combinational from current-cycle inputs and registered state.
- Flag visibility:
  - An instruction that writes flags in cycle t affects a branch only in cycle t+1 or later.
  - A branch in the same cycle as a flag write sees the old flags.
- Stall (pc_en=0): no register changes and taken=0, including when halt=1 in the stalled cycle.
- rst asserted mid-stream, including in HALTED: every register takes its reset value at the next edge, and the next cycle is RUN.
- HALTED: PC frozen at the HLT address, taken=0, FLAG_q and br_count frozen.

## Test plan

- Reset then 3 plain cycles → PC = 0000, 0002, 0004, 0006; FLAG_q=000; br_count=0.
- Flag timing:
  - Cycle t: flag_we=1, FLAG_alu=100.
  - Cycle t: EQ branch (is_B, cond=001) in the same cycle → not taken, because the old Z=0.
  - Cycle t+1: EQ branch at PC=0010, imm9=9'h1FE (−2) → taken, next PC=000E, br_count=1.
- Wrap and saturation:
  - Unconditional is_B at PC=FFFC, imm9=9'h002 → next PC=0002.
  - br_count preloaded to FFFF by forcing many taken branches → stays FFFF.
- Register-indirect priority: is_BR with cond=110 and V=1, reg_target=1234, is_B also asserted → next PC=1234, taken=1.
- Halt and stall:
  - halt with pc_en=0 → no change.
  - halt with pc_en=1 at PC=0040, same cycle as flag_we=1 → halted=1, PC stays 0040, FLAG_q unchanged, taken=0.
  - Later branches are ignored.
- Reset from HALTED: rst for 1 cycle → PC=RESET_PC, halted=0, FLAG_q=000, br_count=0, then normal sequencing resumes.
